alu_operand_stage: RTL

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_pkg.sv | 21 ++
 rtl/operand_fwd_mux.sv | 59 +++++
 rtl/alu_operand_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_operand_pkg.sv
// Shared types and default widths for the ALU operand stage.
package alu_operand_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_IMM_W      = 8;
  localparam int DEF_REG_ADDR_W = 3;
  localparam int STALL_W        = 8;

  typedef enum logic [1:0] {
    SRC_REG,
    SRC_EX,
    SRC_WB,
    SRC_IMM
  } src_sel_e;

  // Increment that sticks at all-ones.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// One operand's source select: immediate, EX forward, WB forward, then register file.
// Forward compare only exists when OPERAND_FWD_EN is defined.
module operand_fwd_mux
  import alu_operand_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  sel_imm,
  input  logic [DATA_W-1:0]     imm_value,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  ex_fwd_valid,
  input  logic [REG_ADDR_W-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0]     ex_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_addr,
  input  logic [DATA_W-1:0]     wb_fwd_data,
  output logic [DATA_W-1:0]     operand,
  output logic                  fwd_hit
);

  logic     ex_match;
  logic     wb_match;
  src_sel_e src;

`ifdef OPERAND_FWD_EN
  // Register 0 is hardwired, so a producer targeting it must never win.
  assign ex_match = ex_fwd_valid && (reg_addr != '0) && (ex_fwd_addr == reg_addr);
  assign wb_match = wb_fwd_valid && (reg_addr != '0) && (wb_fwd_addr == reg_addr);
`else
  logic unused_fwd;
  assign ex_match   = 1'b0;
  assign wb_match   = 1'b0;
  assign unused_fwd = ^{ex_fwd_valid, ex_fwd_addr, ex_fwd_data,
                        wb_fwd_valid, wb_fwd_addr, wb_fwd_data, reg_addr};
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    src = SRC_REG;
    if (sel_imm)       src = SRC_IMM;
    else if (ex_match) src = SRC_EX;
    else if (wb_match) src = SRC_WB;
  end

  always_comb begin
    operand = reg_data;
    case (src)
      SRC_EX:  operand = ex_fwd_data;
      SRC_WB:  operand = wb_fwd_data;
      SRC_IMM: operand = imm_value;
      default: operand = reg_data;
    endcase
  end

  assign fwd_hit = (src == SRC_EX) || (src == SRC_WB);

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch pipeline stage: selects/forwards op_a and op_b and registers them behind a valid/ready handshake.
// Build option: define OPERAND_FWD_EN to enable EX/WB forwarding.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int IMM_W      = DEF_IMM_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [IMM_W-1:0]      imm_data,
  input  logic                  imm_sel,
  input  logic                  imm_sext,
  input  logic                  ex_fwd_valid,
  input  logic [REG_ADDR_W-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0]     ex_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_addr,
  input  logic [DATA_W-1:0]     wb_fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     op_a,
  output logic [DATA_W-1:0]     op_b,
  output logic [1:0]            fwd_hit,
  output logic [STALL_W-1:0]    stall_cnt
);

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;
  logic              hit_a;
  logic              hit_b;
  logic              accept;

  generate
    if (IMM_W == DATA_W) begin : gen_imm_full
      logic unused_sext;
      assign imm_ext     = imm_data;
      assign unused_sext = imm_sext;
    end else begin : gen_imm_ext
      assign imm_ext = {{(DATA_W-IMM_W){imm_sext & imm_data[IMM_W-1]}}, imm_data};
    end
  endgenerate

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_mux_a (
    .sel_imm      (1'b0),
    .imm_value    ('0),
    .reg_addr     (rs_addr),
    .reg_data     (rs_data),
    .ex_fwd_valid (ex_fwd_valid),
    .ex_fwd_addr  (ex_fwd_addr),
    .ex_fwd_data  (ex_fwd_data),
    .wb_fwd_valid (wb_fwd_valid),
    .wb_fwd_addr  (wb_fwd_addr),
    .wb_fwd_data  (wb_fwd_data),
    .operand      (a_next),
    .fwd_hit      (hit_a)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_mux_b (
    .sel_imm      (imm_sel),
    .imm_value    (imm_ext),
    .reg_addr     (rt_addr),
    .reg_data     (rt_data),
    .ex_fwd_valid (ex_fwd_valid),
    .ex_fwd_addr  (ex_fwd_addr),
    .ex_fwd_data  (ex_fwd_data),
    .wb_fwd_valid (wb_fwd_valid),
    .wb_fwd_addr  (wb_fwd_addr),
    .wb_fwd_data  (wb_fwd_data),
    .operand      (b_next),
    .fwd_hit      (hit_b)
  );

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: operand registers are reset too, since their zero reset value is observable on the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      fwd_hit   <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        op_a      <= a_next;
        op_b      <= b_next;
        fwd_hit   <= {hit_b, hit_a};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && !out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

endmodule
